// File: rtl/opb_status_counter_bank_if.sv
// OPB slave-side bus bundle for opb_status_counter_bank.
//
// Purpose: groups the OPB request signals (master -> slave) and the slave
// response signals (slave -> master) of one OPB attachment point.
// Signals:
//   OPB_ABus    [0:31] address
//   OPB_BE      [0:3]  byte enables
//   OPB_DBus    [0:31] write data
//   OPB_RNW            1 = read, 0 = write
//   OPB_select         slave select
//   OPB_seqAddr        sequential address hint
//   Sl_DBus     [0:31] read data
//   Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck  slave responses
// Modports: master (drives OPB_*), slave (drives Sl_*).
interface opb_status_counter_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_status_counter_bank.sv
// opb_status_counter_bank: OPB slave holding per-channel saturating event
// counters, sticky event flags, saturation flags, an irq mask and a
// registered interrupt output.
//
// Ports:
//   OPB_Clk          sole clock; events are already synchronous to it
//   OPB_Rst_n        asynchronous active-low reset
//   bus              OPB slave modport (opb_status_counter_bank_if.slave)
//   event_in[N-1:0]  per-channel event, one count per high cycle
//   irq              registered |(STICKY & MASK)
//
// Register map (byte offset from C_BASEADDR):
//   0x00 STICKY (W1C)   0x04 CTRL   0x08 MASK   0x0C OVF (W1C)
//   0x10+4*i CNT[i] (any write clears)
//
// Optional feature macro: OPB_STATUS_SNAPSHOT_EN. When defined, writing
// CTRL bit0=1 snapshots every counter into a shadow register, CNT reads
// return the shadows and CTRL reads 0x2.
module opb_status_counter_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h01080500,
  parameter logic [31:0] C_HIGHADDR   = 32'h010805FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 8,
  parameter int          C_CNT_WIDTH  = 16,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  opb_status_counter_bank_if.slave    bus,
  input  logic [C_NUM_CH-1:0]         event_in,
  output logic                        irq
);

  // Elaboration-time guards on the supported configuration space.
  if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32 || C_FAMILY == "") begin : g_bad_bus
    $error("opb_status_counter_bank: only a 32-bit OPB is supported");
  end
  if (C_NUM_CH < 1 || C_NUM_CH > 32 || C_CNT_WIDTH < 1 || C_CNT_WIDTH > 32) begin : g_bad_size
    $error("opb_status_counter_bank: C_NUM_CH / C_CNT_WIDTH out of range");
  end
  if ((C_HIGHADDR - C_BASEADDR + 32'd1) < (32'h10 + 32'(4 * C_NUM_CH))) begin : g_bad_span
    $error("opb_status_counter_bank: address span too small for C_NUM_CH");
  end

  typedef enum logic {IDLE, ACK} state_t;

  state_t                   state, state_nxt;
  logic [31:0]              addr, wdata, off, rd_mux, rdata;
  logic [29:0]              word, cnt_word;
  logic                     hit, take, wr;
  logic [C_CNT_WIDTH-1:0]   cnt [C_NUM_CH];
  logic [C_NUM_CH-1:0]      sticky, ovf, mask;
  logic [C_NUM_CH-1:0]      cnt_clr, sticky_clr, ovf_clr, ovf_set;

  // Saturating increment: an all-ones counter holds its value.
  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + C_CNT_WIDTH'(1);
  endfunction

  // OPB [0:31] maps positionally onto [31:0], so register bit k lands on
  // OPB bit 31-k without any explicit reversal.
  assign addr     = bus.OPB_ABus;
  assign wdata    = bus.OPB_DBus;
  assign hit      = bus.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign off      = addr - C_BASEADDR;
  assign word     = off[31:2];
  assign cnt_word = word - 30'd4;
  assign take     = (state == IDLE) && hit;
  assign wr       = take && !bus.OPB_RNW;

  assign sticky_clr = (wr && word == 30'd0) ? wdata[C_NUM_CH-1:0] : '0;
  assign ovf_clr    = (wr && word == 30'd3) ? wdata[C_NUM_CH-1:0] : '0;

  always_comb begin
    cnt_clr = '0;
    ovf_set = '0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      cnt_clr[i] = wr && (word >= 30'd4) && (cnt_word == 30'(i));
      // A clear in the same cycle swallows the event, so no overflow either.
      ovf_set[i] = event_in[i] && !cnt_clr[i] && (&cnt[i]);
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_CH; i++) cnt[i] <= '0;
      sticky <= '0;
      ovf    <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (cnt_clr[i])       cnt[i] <= '0;
        else if (event_in[i]) cnt[i] <= sat_inc(cnt[i]);
      end
      // Set beats write-1-to-clear on the same cycle.
      sticky <= (sticky & ~sticky_clr) | event_in;
      ovf    <= (ovf & ~ovf_clr) | ovf_set;
      if (wr && word == 30'd2) mask <= wdata[C_NUM_CH-1:0];
      irq <= |(sticky & mask);
    end
  end

`ifdef OPB_STATUS_SNAPSHOT_EN
  logic [C_CNT_WIDTH-1:0] shadow [C_NUM_CH];
  logic                   snap;

  assign snap = wr && (word == 30'd1) && wdata[0];

  // Shadows capture the pre-update counter values of the snapshot cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_CH; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < C_NUM_CH; i++) shadow[i] <= cnt[i];
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (word)
      30'd0: rd_mux = 32'(sticky);
`ifdef OPB_STATUS_SNAPSHOT_EN
      30'd1: rd_mux = 32'h0000_0002;
`else
      30'd1: rd_mux = '0;
`endif
      30'd2: rd_mux = 32'(mask);
      30'd3: rd_mux = 32'(ovf);
      default: begin
        for (int i = 0; i < C_NUM_CH; i++) begin
          if (word >= 30'd4 && cnt_word == 30'(i)) begin
`ifdef OPB_STATUS_SNAPSHOT_EN
            rd_mux = 32'(shadow[i]);
`else
            rd_mux = 32'(cnt[i]);
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is only non-zero during the single ACK cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)                rdata <= '0;
    else if (take && bus.OPB_RNW)  rdata <= rd_mux;
    else                           rdata <= '0;
  end

  assign bus.Sl_DBus    = rdata;
  assign bus.Sl_xferAck = (state == ACK);
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.OPB_BE, bus.OPB_seqAddr, wdata, off};

endmodule

// File: doc/opb_status_counter_bank.md
Name: opb_status_counter_bank

Overview:
- Parametrised OPB slave bank of per-channel event counters with sticky flags, an interrupt mask and a registered interrupt output.
- Successor to the single 32-bit simulink-to-PPC status register. It counts pulse events such as 10GbE overruns, not just mirroring a level.
- Sits on the PPC OPB bus beside the other status registers. Events arrive already synchronous to OPB_Clk.

Parameters:
- C_BASEADDR, 32'h01080500, first byte address of the block.
- C_HIGHADDR, 32'h010805FF, last byte address; span must be >= 0x10 + 4*C_NUM_CH.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
- C_NUM_CH, 8, number of event channels; legal range 1..32.
- C_CNT_WIDTH, 16, counter width; legal range 1..32; the value is zero-extended on read.
- C_FAMILY, "virtex5", target family; informational only.

Ports:
- OPB_Clk  in  1  bus clock, sole clock of the block.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- Sl_DBus  out  [0:31]  read data; driven 0 whenever Sl_xferAck=0.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; ignored, all accesses are full-word.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1=read, 0=write.
- OPB_select  in  1  slave select.
- OPB_seqAddr  in  1  ignored.
- event_in  in  [C_NUM_CH-1:0]  per-channel event; a high level in a cycle counts as one event.
- irq  out  1  registered interrupt; high when any (sticky & mask) bit is set.

Behaviour:
- Clock/reset: one clock, OPB_Clk. Reset is asynchronous and active-low (OPB_Rst_n). While reset is low, every output, counter, flag, mask and the FSM are 0/IDLE.
- Bit mapping: register bit k maps to OPB bit [31-k], so the LSB is Sl_DBus[31].
- Address map (offset = ABus - C_BASEADDR):
  - 0x00 STICKY: RO per-channel flags; write-1-to-clear.
  - 0x04 CTRL: see the optional feature.
  - 0x08 MASK: RW irq mask, C_NUM_CH bits.
  - 0x0C OVF: per-channel saturation flags; write-1-to-clear.
  - 0x10+4*i CNT[i]: any write clears counter i.
  - Other in-range offsets: read 0, write ignored, still acked.
- Hit definition: hit = OPB_select & C_BASEADDR <= ABus <= C_HIGHADDR.
- Bus FSM, two states, IDLE and ACK:
  - IDLE -> ACK when hit.
  - ACK -> IDLE unconditionally.
  - Sl_xferAck=1 only in ACK, for exactly one cycle, one cycle after hit.
  - A held select produces acks every second cycle.
- Read path: data is captured on the IDLE->ACK edge and presented on Sl_DBus during ACK. Upper unused bits read 0.
- Write path: the register update takes effect on the IDLE->ACK edge. New values are visible to a read issued on the next transfer.
- Counter per channel:
  - event_in[i]=1 increments CNT[i] by 1.
  - At all-ones, CNT[i] holds its value and sets OVF[i].
  - The same event also sets STICKY[i].
- Simultaneous events:
  - Counter clear and event in the same cycle: clear wins, CNT=0, and that event is lost.
  - STICKY/OVF write-1-clear and set in the same cycle: set wins, flag stays 1.
- irq timing: irq is registered one cycle after STICKY/MASK change. irq = |(STICKY & MASK).
- Reset asserted mid-transfer: FSM returns to IDLE immediately and no ack is issued. The master retries via its timeout.

Optional Feature:
- Macro: OPB_STATUS_SNAPSHOT_EN.
- With the macro defined:
  - Writing CTRL bit0=1 copies all CNT[i] into shadow registers in one cycle.
  - CNT[i] reads return the shadow; shadows reset to 0.
  - CTRL reads bit0=0 and bit1=1 (feature present).
  - A counter clear does not affect its shadow.
- Without the macro: CNT reads return live values; CTRL reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read 0x00, 0x08 and 0x10 -> all 0. Sl_xferAck is one cycle wide, one cycle after select; Sl_DBus is 0 outside ack.
- Pulse event_in[3] for 5 cycles, read 0x1C -> 5. Read 0x00 -> 0x00000008. Write 0x08 to 0x00 -> STICKY reads 0.
- C_CNT_WIDTH=4, 20 events on ch0 -> CNT0 reads 15 and OVF reads 0x1. A write to 0x10 coinciding with an event -> CNT0 reads 0.
- Write MASK=0x2, pulse event_in[1] -> irq=1 two cycles after the pulse. Clear STICKY with an event on the same cycle -> flag and irq stay 1.
- Read offset 0xF0 -> data 0 and acked. Assert OPB_Rst_n=0 during ACK -> no ack, all registers 0.
- Snapshot build: 3 events, write CTRL=1, 2 more events -> CNT reads 3. Non-snapshot build: CNT reads 5 and CTRL reads 0.
